// File: rtl/soc_ram_bist_if.sv
// Single-port 16-bit RAM port as seen by a BIST engine (master) and the RAM (slave).
// The RAM clock is the engine clock, so only the data-path signals live here.
interface soc_ram_bist_if #(
  parameter int ADDR_MSB = 6
);
  logic [ADDR_MSB:0] ram_addr;
  logic              ram_cen;
  logic [1:0]        ram_wen;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;

  modport master (
    output ram_addr,
    output ram_cen,
    output ram_wen,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_addr,
    input  ram_cen,
    input  ram_wen,
    input  ram_din,
    output ram_dout
  );
endinterface

// File: rtl/soc_ram_bist.sv
// March C- self-test engine for a single-port 16-bit RAM: runs M0..M5 over every word
// and reports pass/fail with the first failing address and march element.
module soc_ram_bist #(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              bist_start,
  input  logic              bist_bg,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_MSB:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  soc_ram_bist_if.master    ram
);

  localparam logic [ADDR_MSB:0] LAST_ADDR = (ADDR_MSB+1)'(MEM_SIZE/2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        elem_r, elem_s;
  logic [ADDR_MSB:0] addr_r, addr_s;
  logic              wr_phase_r, wr_phase_s;
  logic              bg_r, bg_s;
  logic              start_ok_s;
  logic              at_end_s;

  logic              run_s, wr_s, rd_now_s;
  logic              cen_s, busy_s, done_s;
  logic [1:0]        wen_s;
  logic [15:0]       din_s, rd_exp_s;
  logic [ADDR_MSB:0] ram_addr_s;

  logic              chk_vld_r;
  logic [15:0]       chk_exp_r;
  logic [ADDR_MSB:0] chk_addr_r;
  logic [2:0]        chk_elem_r;

  function automatic logic [15:0] bg_word(input logic bg, input logic inv);
    logic [15:0] b0;
    b0 = bg ? 16'h5555 : 16'h0000;
    return inv ? ~b0 : b0;
  endfunction

  // M0 and M5 are single-operation elements; M3..M5 walk downwards
  function automatic logic elem_single(input logic [2:0] e);
    return (e == 3'd0) || (e == 3'd5);
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    return (e >= 3'd3);
  endfunction

  // State register: current march position, i.e. the access being driven this cycle
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r    <= ST_IDLE;
      elem_r     <= 3'd0;
      addr_r     <= '0;
      wr_phase_r <= 1'b0;
      bg_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      elem_r     <= elem_s;
      addr_r     <= addr_s;
      wr_phase_r <= wr_phase_s;
      bg_r       <= bg_s;
    end
  end

  // Next-state: advance through read/write phases, addresses and elements
  always_comb begin
    state_s    = state_r;
    elem_s     = elem_r;
    addr_s     = addr_r;
    wr_phase_s = wr_phase_r;
    bg_s       = bg_r;
    start_ok_s = 1'b0;
    at_end_s   = elem_down(elem_r) ? (addr_r == '0) : (addr_r == LAST_ADDR);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          start_ok_s = 1'b1;
          state_s    = ST_RUN;
          elem_s     = 3'd0;
          addr_s     = '0;
          wr_phase_s = 1'b0;
          bg_s       = bist_bg;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (!elem_single(elem_r) && !wr_phase_r) begin
          wr_phase_s = 1'b1;
        end else begin
          wr_phase_s = 1'b0;
          if (at_end_s) begin
            if (elem_r == 3'd5) begin
              state_s = ST_FLUSH;
              addr_s  = '0;
            end else begin
              elem_s = elem_r + 3'd1;
              addr_s = elem_down(elem_r + 3'd1) ? LAST_ADDR : '0;
            end
          end else if (elem_down(elem_r)) begin
            addr_s = addr_r - 1'b1;
          end else begin
            addr_s = addr_r + 1'b1;
          end
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output decode: RAM port values for the next access, plus the read now being issued
  always_comb begin
    run_s      = (state_s == ST_RUN);
    wr_s       = run_s && ((elem_s == 3'd0) || (!elem_single(elem_s) && wr_phase_s));
    cen_s      = !run_s;
    wen_s      = wr_s ? 2'b00 : 2'b11;
    din_s      = wr_s ? bg_word(bg_s, (elem_s == 3'd1) || (elem_s == 3'd3)) : 16'h0000;
    ram_addr_s = run_s ? addr_s : '0;
    busy_s     = run_s || (state_s == ST_FLUSH);
    done_s     = (state_s == ST_DONE);
    rd_now_s   = (state_r == ST_RUN) &&
                 ((elem_r == 3'd5) || ((elem_r != 3'd0) && !wr_phase_r));
    rd_exp_s   = bg_word(bg_r, (elem_r == 3'd2) || (elem_r == 3'd4));
  end

  // Registered RAM port and run status
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ram.ram_addr <= '0;
      ram.ram_cen  <= 1'b1;
      ram.ram_wen  <= 2'b11;
      ram.ram_din  <= 16'h0000;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
    end else begin
      ram.ram_addr <= ram_addr_s;
      ram.ram_cen  <= cen_s;
      ram.ram_wen  <= wen_s;
      ram.ram_din  <= din_s;
      bist_busy    <= busy_s;
      bist_done    <= done_s;
    end
  end

  // Read check: the read issued this cycle is compared against ram_dout next cycle
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      chk_vld_r      <= 1'b0;
      chk_exp_r      <= 16'h0000;
      chk_addr_r     <= '0;
      chk_elem_r     <= 3'd0;
      bist_fail      <= 1'b0;
      bist_fail_addr <= '0;
      bist_fail_elem <= 3'd0;
    end else begin
      chk_vld_r  <= rd_now_s;
      chk_exp_r  <= rd_exp_s;
      chk_addr_r <= addr_r;
      chk_elem_r <= elem_r;
      if (start_ok_s) begin
        bist_fail      <= 1'b0;
        bist_fail_addr <= '0;
        bist_fail_elem <= 3'd0;
      end else if (chk_vld_r && (ram.ram_dout != chk_exp_r) && !bist_fail) begin
        bist_fail      <= 1'b1;
        bist_fail_addr <= chk_addr_r;
        bist_fail_elem <= chk_elem_r;
      end
    end
  end

endmodule

// File: doc/soc_ram_bist.md
# soc_ram_bist

March C- built-in self-test engine for a single-port 16-bit SoC RAM. It sits on the master side of the RAM port, driving address, chip enable, write enable and write data, and checking read data. It runs a full march over every word on a start pulse and reports pass/fail plus the first failing address and march element. It is used in bench and SoC bring-up to qualify the RAM macro or its behavioural model before the CPU is released from reset.

## Interface
- ADDR_MSB, 6: MSB of the word address bus.
- MEM_SIZE, 256: memory size in bytes; word count W = MEM_SIZE/2; addresses 0..W-1.

- mclk  in  1  clock; the RAM clock is the same clock.
- puc_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- bist_start  in  1  start pulse; sampled on a rising mclk edge.
- bist_bg  in  1  background select, captured at start: 0 uses 16'h0000/16'hFFFF, 1 uses 16'h5555/16'hAAAA.
- bist_busy  out  1  high while the march runs.
- bist_done  out  1  high after completion; held until the next accepted start or reset.
- bist_fail  out  1  sticky mismatch flag for the current run.
- bist_fail_addr  out  ADDR_MSB+1  address of the first mismatch.
- bist_fail_elem  out  3  march element (0..5) of the first mismatch.
- ram_addr  out  ADDR_MSB+1  RAM word address.
- ram_cen  out  1  RAM chip enable, active low.
- ram_wen  out  2  RAM byte write enables, active low. The engine only drives 2'b00 (write) or 2'b11 (read/idle).
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data. Valid in the cycle after a read is issued.

## Operation
- States: IDLE, RUN, FLUSH, DONE. All RAM-side outputs are registered.
- Background values: B0 = bg ? 16'h5555 : 16'h0000. B1 = ~B0.
- IDLE or DONE with bist_start=1 moves to RUN:
  - clears bist_done, bist_fail, bist_fail_addr and bist_fail_elem;
  - captures bist_bg;
  - sets element=0 and addr=0.
- bist_start is ignored in RUN and FLUSH.
- March elements, issued in order. ↑ means addresses 0 to W-1; ↓ means W-1 to 0.
  - M0 ↑ w B0.
  - M1 ↑ r B0, w B1.
  - M2 ↑ r B1, w B0.
  - M3 ↓ r B0, w B1.
  - M4 ↓ r B1, w B0.
  - M5 ↓ r B0.
- Cycle cost: a read+write element takes 2 cycles per address (read cycle, then write cycle to the same address). M0 and M5 take 1 cycle per address.
- Element transitions: on the last address of an element, the next element starts in the very next cycle with no idle gap. Its address is 0 for ↑ or W-1 for ↓.
- Read check pipeline:
  - Each issued read registers {expected, addr, element}.
  - In the following cycle, ram_dout is compared over all 16 bits.
  - A mismatch sets bist_fail. If bist_fail was 0, it also captures the address and element.
  - Later mismatches set nothing new. The run always completes; it never aborts.
- FLUSH: one cycle after the last M5 read, with ram_cen=1, to check that read. Then DONE: bist_busy=0, bist_done=1.
- Address counter width is ADDR_MSB+1. Terminal counts are compared against 0 and W-1, never by overflow. W need not be a power of two.

## Timing
- Reset values: bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0, bist_fail_elem=0, ram_cen=1, ram_wen=2'b11, ram_addr=0, ram_din=0.
- The same values are driven in IDLE and DONE, except that in DONE bist_done=1 and the fail fields are held.
- Start accepted at edge E0. The first RAM access (M0, addr 0) is driven in the cycle following E0, and bist_busy rises at E0.
- bist_busy stays high for exactly 10W+1 cycles: M0 W, M1–M4 2W each, M5 W, FLUSH 1.
- bist_done rises at the same edge bist_busy falls.
- Fail outputs update at the edge ending the compare cycle. That is one cycle after the read's access cycle.
- Read/write pairs:
  - Read in cycle N (ram_cen=0, ram_wen=11).
  - Write in cycle N+1 (ram_cen=0, ram_wen=00, same address). The compare of the read data happens in cycle N+1.
  - The RAM latches the write and the new read address at the end of N+1, so the compare sees pre-write data.
- Reset mid-run: all state returns to reset values asynchronously. The RAM port goes idle immediately. No done or fail is reported for the aborted run.
- A start held high across multiple cycles is accepted once. It re-triggers only after DONE if it is still high.

## Test plan
- Reset then idle: assert puc_rst for 3 cycles with bist_start=0. Required: ram_cen=1, ram_wen=11, busy, done and fail all 0. Nothing changes over 20 cycles.
- Fault-free run: defaults (W=128), bg=0, pulse start. Required:
  - busy for 1281 cycles, then done=1 and fail=0;
  - the first 128 accesses write 16'h0000 to addr 0..127;
  - M3's first access is a read of addr 127.
- Stuck-at-0: the RAM model forces bit 3 of word 0x2A to 0. Required: done=1, fail=1, fail_addr=0x2A, fail_elem=2 (first r B1 of 16'hFFFF).
- Alternate background: bg=1. Required: M0 writes 16'h5555 and M1 writes 16'hAAAA. A stuck-at-1 on bit 1 of word 0x10 gives fail_addr=0x10, fail_elem=1.
- Start while busy, then reset mid-run:
  - Pulse start at cycle 100 of a run. Required: ignored, busy length still 1281.
  - New run, assert reset at cycle 300. Required: ram_cen=1 immediately, busy=0, done=0.
- Restart from DONE after a failing run with the fault removed. Required: fail clears at the start edge, and the run ends with done=1, fail=0.
